// File: rtl/matrix_result_unpacker.sv
// Purpose    : snapshots a 256-bit 4x4 math-unit result off the shared bus and
//              replays it to matrix memory as 16 sequential element writes.
// Latency    : first write presented the cycle after capture; done one cycle
//              after the 16th write is accepted.
// Backpressure: mem_ready low holds mem_wr_en/mem_addr/mem_wdata stable; a
//              capture arriving mid-transfer is dropped and flagged on overrun.
//
// Ports:
//   clk, reset (async, active-low)
//   capture, data_bus, base_addr   - result snapshot request from the bus
//   col_major                      - transpose-on-write select (COL_MAJOR_EN only)
//   mem_wr_en, mem_addr, mem_wdata, mem_ready - element write handshake
//   busy, done, overrun            - status (all registered)
//
// Optional build macro: COL_MAJOR_EN adds the col_major input. When it is
// sampled high with capture, write k carries element (row=k%4, col=k/4), so
// memory receives the transpose of the bus result.
module matrix_result_unpacker #(
    parameter int ELEM_W = 16,
    parameter int ADDR_W = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 capture,
    input  logic [16*ELEM_W-1:0] data_bus,
    input  logic [ADDR_W-1:0]    base_addr,
`ifdef COL_MAJOR_EN
    input  logic                 col_major,
`endif
    output logic                 mem_wr_en,
    output logic [ADDR_W-1:0]    mem_addr,
    output logic [ELEM_W-1:0]    mem_wdata,
    input  logic                 mem_ready,
    output logic                 busy,
    output logic                 done,
    output logic                 overrun
);

    localparam int BUS_W = 16 * ELEM_W;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             state_q;
    state_t             state_d;
    logic [BUS_W-1:0]   res_q;
    logic [ADDR_W-1:0]  base_q;
    logic [3:0]         idx_q;
    logic [3:0]         idx_d;
    logic               cm_q;

    logic               load;
    logic [3:0]         idx_inc;
    logic [3:0]         sel_elem;
    logic [ELEM_W-1:0]  next_elem;

    logic               wr_en_d;
    logic [ADDR_W-1:0]  addr_d;
    logic [ELEM_W-1:0]  wdata_d;
    logic               busy_d;
    logic               done_d;
    logic               overrun_d;

    // Map write order k to the flat element position row*4+col.
    // Row-major: position = k. Column-major: row=k%4, col=k/4, so the two
    // 2-bit halves of k swap.
    function automatic logic [3:0] elem_of(input logic [3:0] k, input logic cm);
        elem_of = cm ? {k[1:0], k[3:2]} : k;
    endfunction

    // A capture is honoured whenever no transfer is in flight; DONE counts as
    // free so back-to-back results do not lose a cycle.
    assign load      = capture && ((state_q == IDLE) || (state_q == DONE));
    assign idx_inc   = idx_q + 4'd1;
    assign sel_elem  = elem_of(idx_inc, cm_q);
    assign next_elem = res_q[sel_elem*ELEM_W +: ELEM_W];

    // ------------------------------------------------------------------
    // State register and registered outputs
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            idx_q     <= 4'd0;
            mem_wr_en <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            mem_wr_en <= wr_en_d;
            mem_addr  <= addr_d;
            mem_wdata <= wdata_d;
            busy      <= busy_d;
            done      <= done_d;
            overrun   <= overrun_d;
        end
    end

    // Snapshot storage: contents are irrelevant until the first capture, so
    // it carries no reset.
    always_ff @(posedge clk) begin
        if (load) begin
            res_q  <= data_bus;
            base_q <= base_addr;
        end
    end

`ifdef COL_MAJOR_EN
    always_ff @(posedge clk) begin
        if (load) begin
            cm_q <= col_major;
        end
    end
`else
    assign cm_q = 1'b0;
`endif

    // ------------------------------------------------------------------
    // Next-state and next-output logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        wr_en_d   = mem_wr_en;
        addr_d    = mem_addr;
        wdata_d   = mem_wdata;
        busy_d    = busy;
        done_d    = 1'b0;
        overrun_d = 1'b0;

        case (state_q)
            IDLE, DONE: begin
                if (load) begin
                    // Element 0 is at position 0 in either order, so the
                    // first write comes straight from the bus.
                    state_d = SEND;
                    idx_d   = 4'd0;
                    wr_en_d = 1'b1;
                    addr_d  = base_addr;
                    wdata_d = data_bus[ELEM_W-1:0];
                    busy_d  = 1'b1;
                end else begin
                    state_d = IDLE;
                    wr_en_d = 1'b0;
                    addr_d  = '0;
                    wdata_d = '0;
                    busy_d  = 1'b0;
                end
            end

            SEND: begin
                busy_d    = 1'b1;
                overrun_d = capture;
                if (mem_ready) begin
                    if (idx_q == 4'd15) begin
                        state_d = DONE;
                        wr_en_d = 1'b0;
                        addr_d  = '0;
                        wdata_d = '0;
                        done_d  = 1'b1;
                    end else begin
                        // Address wraps naturally in ADDR_W bits.
                        idx_d   = idx_inc;
                        addr_d  = base_q + ADDR_W'(idx_inc);
                        wdata_d = next_elem;
                    end
                end
            end

            default: begin
                state_d = IDLE;
                wr_en_d = 1'b0;
                addr_d  = '0;
                wdata_d = '0;
                busy_d  = 1'b0;
            end
        endcase
    end

endmodule
